// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding and
// the PC alignment mask.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    VALID = 3'd2,
    DROP  = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  // Low PC bits that must be zero for a word-aligned fetch.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_register.sv
// Generic write-enabled register with asynchronous active-high reset.
module Register #(
  parameter int                   BIT_WIDTH   = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wrtEn,
  input  logic [BIT_WIDTH-1:0] dataIn,
  output logic [BIT_WIDTH-1:0] dataOut
);

  // Load dataIn when enabled; reset forces RESET_VALUE immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      dataOut <= RESET_VALUE;
    else if (wrtEn) dataOut <= dataIn;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request per PC,
// presents the returned word downstream and grants the PC register its +4.
// Optional build macro FETCH_PERF_CNT_EN adds the fetchCount output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] pc,
  input  logic             flush,
  input  logic             stallIn,
  output logic             imemReq,
  output logic [DBITS-1:0] imemAddr,
  input  logic             imemAck,
  input  logic [31:0]      imemData,
  output logic [31:0]      instOut,
  output logic [DBITS-1:0] instPc,
  output logic             instValid,
  output logic             pcAdvance,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]      fetchCount,
`endif
  output logic             fault
);

  fetch_state_e     state, state_next;
  logic             fresh;     // first cycle of a FETCH: address comes straight from pc
  logic             restart;   // next cycle is a fresh FETCH
  logic             bad_pc;
  logic [DBITS-1:0] addr_q;

  // The PC register only updates at the edge that enters FETCH, so the first
  // FETCH cycle uses pc live and captures it; later cycles replay the capture.
  assign imemAddr = fresh ? pc : addr_q;
  assign bad_pc   = fresh && is_misaligned(pc[1:0]);

  // State, fresh-entry flag and captured request address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      fresh  <= 1'b0;
      addr_q <= '0;
    end else begin
      state <= state_next;
      fresh <= restart;
      if (fresh) addr_q <= pc;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    imemReq    = 1'b0;
    pcAdvance  = 1'b0;
    instValid  = 1'b0;
    fault      = 1'b0;
    unique case (state)
      IDLE: begin
        state_next = FETCH;
        restart    = 1'b1;
      end
      FETCH: begin
        if (bad_pc) begin
          if (flush) begin
            state_next = FETCH;
            restart    = 1'b1;
          end else begin
            fault      = 1'b1;
            state_next = FAULT;
          end
        end else begin
          imemReq = 1'b1;
          if (imemAck && !flush) begin
            pcAdvance  = 1'b1;
            state_next = VALID;
          end else if (imemAck && flush) begin
            state_next = FETCH;
            restart    = 1'b1;
          end else if (flush) begin
            state_next = DROP;
          end
        end
      end
      DROP: begin
        imemReq = 1'b1;
        if (!flush && imemAck) begin
          state_next = FETCH;
          restart    = 1'b1;
        end
      end
      VALID: begin
        instValid = 1'b1;
        if (flush || !stallIn) begin
          state_next = FETCH;
          restart    = 1'b1;
        end
      end
      FAULT: begin
        fault = 1'b1;
        if (flush) begin
          state_next = FETCH;
          restart    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  Register #(
    .BIT_WIDTH  (32),
    .RESET_VALUE('0)
  ) u_inst_reg (
    .clk    (clk),
    .reset  (reset),
    .wrtEn  (pcAdvance),
    .dataIn (imemData),
    .dataOut(instOut)
  );

  Register #(
    .BIT_WIDTH  (DBITS),
    .RESET_VALUE('0)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .wrtEn  (pcAdvance),
    .dataIn (imemAddr),
    .dataOut(instPc)
  );

`ifdef FETCH_PERF_CNT_EN
  // Count instructions consumed downstream; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    fetchCount <= '0;
    else if (state == VALID && !stallIn && !flush) fetchCount <= fetchCount + 32'd1;
  end
`endif

endmodule
